mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-master arbiter and sequencer for the processor's single synchronous memory port. Master 0 is the processor's control path (ADDR/DOUT/W_D). Master 1 is a secondary requester such as a program loader or DMA. The block grants the port to one master at a time, drives the registered memory address, write-data and write-enable, and returns an acknowledge with read data after the memory's 1-cycle read latency.

## Interface
Parameters:
- `ADDR_W`, default 7, memory address width (128 words).
- `DATA_W`, default 10, memory word width (matches instruction width).

Ports:
- `clock`, in, 1: single clock. All state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low. 0 forces the reset state immediately.
- `req0`, `req1`, in, 1: access request, held high until the matching ack.
- `we0`, `we1`, in, 1: 1 = write, 0 = read. Sampled with the address at grant.
- `addr0`, `addr1`, in, `ADDR_W`: access address.
- `wdata0`, `wdata1`, in, `DATA_W`: write data.
- `gnt0`, `gnt1`, out, 1: high while that master's access is in ACCESS.
- `ack0`, `ack1`, out, 1: one-cycle completion pulse.
- `rdata0`, `rdata1`, out, `DATA_W`: equals `mem_rdata` while that master's ack is high and the access is a read; 0 otherwise.
- `mem_addr`, out, `ADDR_W`: registered memory address.
- `mem_wdata`, out, `DATA_W`: registered memory write data.
- `mem_we`, out, 1: memory write enable.
- `mem_rdata`, in, `DATA_W`: synchronous memory output, valid 1 cycle after the address edge.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `owner`, out, 1: index of the master currently or last served.

## Operation
State machine: IDLE, ACCESS, RESP.

- **IDLE**
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requesting: round-robin; the master not equal to `owner` wins.
  - On grant: at the edge, latch `mem_addr`/`mem_wdata`/`mem_we` from the winner, set `owner` to the winner, go to ACCESS.
- **ACCESS**
  - `gnt[owner]` = 1. Memory sees the registered address, and `mem_we` for writes.
  - Next edge: clear `mem_we`, go to RESP.
- **RESP**
  - `ack[owner]` = 1. For reads, `rdata[owner]` = `mem_rdata`.
  - The current owner's req is ignored in RESP, since it is still high this cycle.
  - If the other master's req = 1: latch its request, set `owner` to it, go to ACCESS (back-to-back).
  - Otherwise go to IDLE.
- A master that keeps req high after its ack is treated as a new request in IDLE.
- Inputs are sampled only at the grant edge. Changes to addr/we/wdata, or a dropped req, after grant have no effect; the access completes and is acked.
- A req dropped before grant produces no memory activity.
- `mem_we` is high for exactly one cycle per write and never during reads, IDLE or RESP.

## Timing
- Reset values:
  - state = IDLE, `owner` = 1, so master 0 wins the first tie.
  - All outputs 0: `gnt*`, `ack*`, `rdata*`, `mem_addr`, `mem_wdata`, `mem_we`, `busy`.
- Latency: req high in cycle N (IDLE) → gnt in N+1 → ack and read data in N+2.
- Throughput:
  - 3 cycles per isolated access.
  - 2 cycles per access when both masters keep requesting, which alternates M0, M1, M0, …
- Reset asserted mid-access:
  - Immediate return to IDLE with all outputs 0.
  - No ack is issued for the aborted access.
  - Any write in progress is cut: `mem_we` drops asynchronously.
- Simultaneous req0 and req1 in RESP while M0 is owner: M1 is granted next. M0's held req is served afterwards.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN` defined:
  - Master 0 always wins ties in IDLE.
  - In RESP with M1 as owner, a pending req0 goes to ACCESS for M0.
  - In RESP with M0 as owner, a pending req1 is granted only if req0 = 0; otherwise M0 is re-granted without passing through IDLE.
  - M1 can starve.
- Not defined: round-robin as described in Operation (default).

## Test plan
- **Reset state:** hold `reset` = 0, then release → all outputs 0, `busy` = 0, `owner` = 1.
- **M0 write then read:**
  - req0 = 1, we0 = 1, addr0 = 5, wdata0 = 0x155 → gnt0 next cycle with `mem_addr` = 5, `mem_we` = 1, `mem_wdata` = 0x155; ack0 the following cycle.
  - Read of addr 5 → ack0 with rdata0 = 0x155, `mem_we` = 0 throughout.
- **Tie from reset:** req0 and req1 both read, held continuously → grants alternate M0, M1, M0 with 2 cycles between acks. `owner` toggles each grant.
- **Late changes ignored:** M1 changes addr1 from 3 to 9 during ACCESS → `mem_addr` stays 3; ack1 is still issued.
- **Reset mid-access:** pull `reset` low during ACCESS of a write → `mem_we` and `gnt` drop immediately, no ack. After release, state is IDLE.
- **Fixed priority:** with `MEM_ARB_FIXED_PRIO_EN`, req0 and req1 held high → only M0 is served, every 2 cycles, until req0 drops. M1 is granted on the next arbitration after that.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Grants the processor's single synchronous memory port to one of two
// masters at a time. Master 0 is the control path, master 1 a secondary
// requester (loader/DMA). The winner's address, write data and write enable
// are registered onto the memory port. An acknowledge, carrying read data
// for reads, follows one cycle later, once the memory's read latency has
// elapsed.
//
// Optional build macro:
//   MEM_ARB_FIXED_PRIO_EN - master 0 always wins and may be re-granted
//                           directly from RESP; master 1 can starve.
//                           Undefined (default): round-robin.
//
// Ports:
//   clock, reset          - rising-edge clock, async active-low reset
//   req0/1, we0/1         - request and write flag per master
//   addr0/1, wdata0/1     - access address and write data per master
//   gnt0/1                - high while that master's access is in ACCESS
//   ack0/1                - one-cycle completion pulse
//   rdata0/1              - read data during a read ack, 0 otherwise
//   mem_addr/wdata/we     - registered memory port
//   mem_rdata             - memory output, valid one cycle after the address
//   busy                  - state is not IDLE
//   owner                 - master currently or last served
//   dbg_state             - FSM state (0 IDLE, 1 ACCESS, 2 RESP)
//
// Handshake: a master raises reqN and holds it until ackN. Address, we and
// wdata are sampled only on the grant edge; later changes, including a
// dropped req, do not affect the access, which completes and is acked. A req
// still high after its ack is a new request.

module mem_port_arbiter #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner,
   output logic [1:0]        dbg_state
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   logic [1:0] state;
   logic [1:0] next_state;
   logic       grant;
   logic       winner;
   logic       acc_we;   // current access is a write; gates read data in RESP

   always_comb begin
      next_state = state;
      grant      = 1'b0;
      winner     = 1'b0;
      case (state)
         S_IDLE: begin
            if (req0 && req1) begin
               grant = 1'b1;
`ifdef MEM_ARB_FIXED_PRIO_EN
               winner = 1'b0;
`else
               winner = ~owner;
`endif
            end else if (req0) begin
               grant  = 1'b1;
               winner = 1'b0;
            end else if (req1) begin
               grant  = 1'b1;
               winner = 1'b1;
            end
         end
         S_ACCESS: begin
            next_state = S_RESP;
         end
         S_RESP: begin
            next_state = S_IDLE;
`ifdef MEM_ARB_FIXED_PRIO_EN
            // Master 0's req is honoured even while it owns the port, so it
            // is re-granted back-to-back and can lock master 1 out.
            if (owner) begin
               if (req0) begin
                  grant  = 1'b1;
                  winner = 1'b0;
               end
            end else if (req1 && !req0) begin
               grant  = 1'b1;
               winner = 1'b1;
            end else if (req0) begin
               grant  = 1'b1;
               winner = 1'b0;
            end
`else
            // The owner's req is still high while it is being acked, so only
            // the other master can be served back-to-back.
            if (owner ? req0 : req1) begin
               grant  = 1'b1;
               winner = ~owner;
            end
`endif
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
      if (grant) begin
         next_state = S_ACCESS;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         owner     <= 1'b1;   // master 0 wins the first tie
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         acc_we    <= 1'b0;
      end else begin
         state  <= next_state;
         // Write enable lives only for the ACCESS cycle that follows a grant.
         mem_we <= 1'b0;
         if (grant) begin
            owner     <= winner;
            mem_addr  <= winner ? addr1  : addr0;
            mem_wdata <= winner ? wdata1 : wdata0;
            mem_we    <= winner ? we1    : we0;
            acc_we    <= winner ? we1    : we0;
         end
      end
   end

   assign gnt0      = (state == S_ACCESS) && !owner;
   assign gnt1      = (state == S_ACCESS) &&  owner;
   assign ack0      = (state == S_RESP)   && !owner;
   assign ack1      = (state == S_RESP)   &&  owner;
   assign rdata0    = (ack0 && !acc_we) ? mem_rdata : '0;
   assign rdata1    = (ack1 && !acc_we) ? mem_rdata : '0;
   assign busy      = (state != S_IDLE);
   assign dbg_state = state;

endmodule
